// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder
//
// Watches the registered 4-bit outputs of NUM_SRC neuron blocks and turns
// every new non-zero output into an address-event word {source id, value}.
// Each source owns a single pending slot. A round-robin arbiter moves at most
// one pending event per cycle into a circular FIFO, which drains over a
// valid/ready stream. When an event lands on a slot that is still occupied
// and is not being granted, the old event is lost and counted as a drop.
//
// Ports:
//   clk         single clock
//   rst         asynchronous active-high reset
//   src_in      neuron outputs, source k in bits [4k+3:4k]
//   out_valid   AER word available at the FIFO head
//   out_ready   consumer accepts the head word
//   out_data    {src_id, value}, src_id in the MSBs
//   fifo_level  current FIFO occupancy
//   drop_count  saturating count of lost events
//   overflow    sticky flag, set on any drop
//   clr_drop    synchronous clear of drop_count and overflow
//
// Latency: a src_in change captured at edge E0 reaches the pending slot at
// E1 and, with an empty FIFO and no contention, the FIFO at E2, so out_valid
// rises 3 edges after src_in changes. out_valid/out_data are decoded from
// registers only; out_ready never reaches them combinationally.

module spike_aer_encoder #(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [4*NUM_SRC-1:0]            src_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(NUM_SRC)+3:0]      out_data,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [CNT_W-1:0]                drop_count,
  output logic                            overflow,
  input  logic                            clr_drop
);

  localparam int ID_W   = $clog2(NUM_SRC);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = AW + 1;
  localparam int WORD_W = ID_W + 4;
  // Up to NUM_SRC drops can occur in one cycle.
  localparam int DCNT_W = ID_W + 1;
  // Sum width large enough that counter + per-cycle drops never wraps.
  localparam int SUM_W  = ((CNT_W > DCNT_W) ? CNT_W : DCNT_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Number of set bits in the per-source drop vector.
  function automatic logic [DCNT_W-1:0] count_ones(input logic [NUM_SRC-1:0] v);
    logic [DCNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      n = n + DCNT_W'(v[i]);
    end
    return n;
  endfunction

  // Add the drops of this cycle to a count, clamping at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [DCNT_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'(CNT_MAX)) begin
      return CNT_MAX;
    end
    return s[CNT_W-1:0];
  endfunction

  logic [3:0]          src_q    [NUM_SRC];
  logic [3:0]          src_prev [NUM_SRC];
  logic [NUM_SRC-1:0]  evt;

  logic [NUM_SRC-1:0]  pend_vld;
  logic [3:0]          pend_val [NUM_SRC];

  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     arb_idx;
  logic [ID_W-1:0]     grant_id;
  logic                grant_any;
  logic [NUM_SRC-1:0]  grant;

  logic [NUM_SRC-1:0]  drop;
  logic [DCNT_W-1:0]   drop_num;

  logic [WORD_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [LVL_W-1:0]    level;
  logic                full;
  logic                push;
  logic                pop;

  // ---- Stage 0: sample neuron outputs and keep the previous sample ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        src_q[k]    <= '0;
        src_prev[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        src_q[k]    <= src_in[4*k +: 4];
        src_prev[k] <= src_q[k];
      end
    end
  end

  // A held non-zero value fires once; a return to zero never fires.
  always_comb begin
    evt = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      evt[k] = (src_q[k] != 4'd0) && (src_q[k] != src_prev[k]);
    end
  end

  // ---- Stage 1: per-source pending slots and round-robin arbitration ----
  // Full is taken before any pop, so a full FIFO blocks the grant even when
  // the consumer frees an entry in the same cycle.
  assign full = (level == LVL_W'(FIFO_DEPTH));

  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    arb_idx   = '0;
    if (!full) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        // ID_W-bit addition wraps modulo NUM_SRC since NUM_SRC is a power of 2.
        arb_idx = ptr + ID_W'(i);
        if (!grant_any && pend_vld[arb_idx]) begin
          grant_any = 1'b1;
          grant_id  = arb_idx;
        end
      end
    end
    if (grant_any) begin
      grant[grant_id] = 1'b1;
    end
  end

  // An occupied slot that is not leaving this cycle loses its old event.
  always_comb begin
    drop = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      drop[k] = evt[k] && pend_vld[k] && !grant[k];
    end
  end

  assign drop_num = count_ones(drop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld <= '0;
      ptr      <= '0;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (evt[k]) begin
          pend_vld[k] <= 1'b1;
        end else if (grant[k]) begin
          pend_vld[k] <= 1'b0;
        end
      end
      if (grant_any) begin
        ptr <= grant_id + ID_W'(1);
      end
    end
  end

  // Slot payload is qualified by pend_vld, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_SRC; k++) begin
      if (evt[k]) begin
        pend_val[k] <= src_q[k];
      end
    end
  end

  // ---- Stage 2: event FIFO and output stream ----
  assign push = grant_any;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {grant_id, pend_val[grant_id]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign out_valid  = (level != '0);
  // Memory content is not reset, so the head is masked while empty.
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign fifo_level = level;

  // ---- Drop accounting ----
  // A clear in a cycle that also drops restarts the count from those drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (clr_drop) begin
      drop_count <= sat_add('0, drop_num);
      overflow   <= |drop;
    end else begin
      drop_count <= sat_add(drop_count, drop_num);
      if (|drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Self-checking bench for spike_aer_encoder. The main instance uses the
// default parameters; a second instance with a 2-bit drop counter covers
// saturation and clear. Expected AER words go into a queue as stimulus is
// applied and a negedge monitor pops and compares them on every handshake.

module tb_spike_aer_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [15:0] src_in;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_data;
  logic [3:0]  fifo_level;
  logic [7:0]  drop_count;
  logic        overflow;
  logic        clr_drop;

  logic [15:0] src_in2;
  logic        out_valid2;
  logic        out_ready2;
  logic [5:0]  out_data2;
  logic [3:0]  fifo_level2;
  logic [1:0]  drop_count2;
  logic        overflow2;
  logic        clr_drop2;

  int          n_tests = 0;
  int          n_fail  = 0;

  logic [5:0]  exp_q[$];
  logic [5:0]  mon_exp;
  bit          record_mode = 1'b0;
  logic [1:0]  id_log[$];

  spike_aer_encoder #(.NUM_SRC(4), .FIFO_DEPTH(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_in     (src_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_level (fifo_level),
    .drop_count (drop_count),
    .overflow   (overflow),
    .clr_drop   (clr_drop)
  );

  spike_aer_encoder #(.NUM_SRC(4), .FIFO_DEPTH(8), .CNT_W(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .src_in     (src_in2),
    .out_valid  (out_valid2),
    .out_ready  (out_ready2),
    .out_data   (out_data2),
    .fifo_level (fifo_level2),
    .drop_count (drop_count2),
    .overflow   (overflow2),
    .clr_drop   (clr_drop2)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: a handshake seen at negedge pops on the next posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (record_mode) begin
        id_log.push_back(out_data[5:4]);
      end else begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_extra: got word %h, expected no word", out_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (out_data !== mon_exp) begin
            n_fail++;
            $display("FAIL scoreboard_word: got %h, expected %h", out_data, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    src_in     = '0;
    src_in2    = '0;
    out_ready  = 1'b0;
    out_ready2 = 1'b0;
    clr_drop   = 1'b0;
    clr_drop2  = 1'b0;
    #2 rst = 1'b1;
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (out_data !== 6'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    n_tests++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_tests++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_tests++; if (out_valid2 !== 1'b0 || drop_count2 !== 2'd0) begin n_fail++; $display("FAIL reset_dut2: got valid %b cnt %0d want 0 0", out_valid2, drop_count2); end
  endtask

  task automatic test_single_event;
    apply_reset();
    out_ready = 1'b1;
    exp_q.push_back(6'h15);
    src_in[7:4] = 4'd5;
    tick(); tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: out_valid got %b want 0 after 2 edges", out_valid); end
    tick();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: out_valid got %b want 1 after 3 edges", out_valid); end
    n_tests++; if (out_data !== 6'h15) begin n_fail++; $display("FAIL single_data: got %h want 15", out_data); end
    repeat (8) tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_hold: out_valid got %b want 0 while value held", out_valid); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_drained: %0d words outstanding, want 0", exp_q.size()); end
    src_in[7:4] = 4'd0;
    repeat (6) tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_zero: out_valid got %b want 0 after return to zero", out_valid); end
  endtask

  task automatic test_simultaneous;
    logic [5:0] w [4];
    w[0] = 6'h01; w[1] = 6'h12; w[2] = 6'h23; w[3] = 6'h34;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(w[i]);
    src_in = 16'h4321;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== w[i]) begin
        n_fail++;
        $display("FAIL simul_word%0d: got valid %b data %h want 1 %h", i, out_valid, out_data, w[i]);
      end
      tick();
    end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL simul_end: out_valid got %b want 0", out_valid); end
    n_tests++; if (dut.ptr !== 2'd0) begin n_fail++; $display("FAIL simul_ptr: got %0d want 0", dut.ptr); end
  endtask

  task automatic test_backpressure;
    logic [1:0] sid;
    logic [3:0] val;
    apply_reset();
    out_ready = 1'b0;
    for (int t = 0; t < 16; t++) begin
      sid = 2'(t % 4);
      val = 4'((t % 15) + 1);
      src_in[4*(t%4) +: 4] = val;
      if (t < 8 || t >= 12) exp_q.push_back({sid, val});
      tick();
      if (t == 5) begin
        n_tests++; if (out_data !== 6'h01) begin n_fail++; $display("FAIL bp_head_early: got %h want 01", out_data); end
      end
      if (t == 11) begin
        n_tests++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL bp_full: level got %0d want 8", fifo_level); end
      end
      if (t == 12) begin
        n_tests++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL bp_no_early_drop: got %0d want 0", drop_count); end
      end
    end
    repeat (3) tick();
    n_tests++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL bp_level_hold: got %0d want 8", fifo_level); end
    n_tests++; if (drop_count !== 8'd4) begin n_fail++; $display("FAIL bp_drops: got %0d want 4", drop_count); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow: got %b want 1", overflow); end
    n_tests++; if (out_valid !== 1'b1 || out_data !== 6'h01) begin n_fail++; $display("FAIL bp_head_stable: got valid %b data %h want 1 01", out_valid, out_data); end
    out_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) tick();
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain: %0d words outstanding, want 0", exp_q.size()); end
    repeat (2) tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_fairness;
    logic ph;
    int   bad;
    int   n0;
    int   n2;
    ph  = 1'b0;
    bad = 0;
    n0  = 0;
    n2  = 0;
    apply_reset();
    id_log.delete();
    record_mode = 1'b1;
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (cyc % 2 == 0) begin
        ph = ~ph;
        src_in[3:0]  = ph ? 4'd3 : 4'd5;
        src_in[11:8] = ph ? 4'd6 : 4'd9;
      end
      out_ready = (cyc >= 16) && (cyc % 4 == 0);
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 40 && out_valid; c++) tick();
    record_mode = 1'b0;
    out_ready = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fair_drain: out_valid got %b want 0", out_valid); end
    n_tests++; if (id_log.size() < 10) begin n_fail++; $display("FAIL fair_count: got %0d words want at least 10", id_log.size()); end
    for (int i = 0; i < id_log.size(); i++) begin
      if (id_log[i] == 2'd0) n0++;
      else if (id_log[i] == 2'd2) n2++;
      else bad++;
      if (i > 0 && id_log[i] == id_log[i-1]) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL fair_alternate: got %0d violations want 0", bad); end
    n_tests++; if (n0 == 0 || n2 == 0 || (n0 - n2) > 1 || (n2 - n0) > 1) begin n_fail++; $display("FAIL fair_starve: got src0 %0d src2 %0d want balanced", n0, n2); end
    n_tests++; if (id_log.size() == 0 || id_log[0] !== 2'd0) begin n_fail++; $display("FAIL fair_first: first grant not source 0"); end
  endtask

  task automatic test_saturation;
    apply_reset();
    out_ready2 = 1'b0;
    for (int t = 0; t < 14; t++) begin
      src_in2[3:0] = 4'(t + 1);
      tick();
      if (t == 11) begin
        n_tests++; if (drop_count2 !== 2'd2) begin n_fail++; $display("FAIL sat_mid: got %0d want 2", drop_count2); end
      end
      if (t == 13) begin
        n_tests++; if (drop_count2 !== 2'd3) begin n_fail++; $display("FAIL sat_clamp4: got %0d want 3", drop_count2); end
      end
    end
    tick();
    n_tests++; if (drop_count2 !== 2'd3 || overflow2 !== 1'b1) begin n_fail++; $display("FAIL sat_five: got cnt %0d ovf %b want 3 1", drop_count2, overflow2); end
    n_tests++; if (fifo_level2 !== 4'd8) begin n_fail++; $display("FAIL sat_level: got %0d want 8", fifo_level2); end
    clr_drop2 = 1'b1;
    tick();
    clr_drop2 = 1'b0;
    n_tests++; if (drop_count2 !== 2'd0 || overflow2 !== 1'b0) begin n_fail++; $display("FAIL clr_quiet: got cnt %0d ovf %b want 0 0", drop_count2, overflow2); end
    src_in2[3:0] = 4'd15;
    tick();
    clr_drop2 = 1'b1;
    tick();
    clr_drop2 = 1'b0;
    n_tests++; if (drop_count2 !== 2'd1 || overflow2 !== 1'b1) begin n_fail++; $display("FAIL clr_with_drop: got cnt %0d ovf %b want 1 1", drop_count2, overflow2); end
    repeat (2) tick();
    n_tests++; if (drop_count2 !== 2'd1) begin n_fail++; $display("FAIL clr_after: got %0d want 1", drop_count2); end
  endtask

  task automatic test_reset_mid;
    apply_reset();
    out_ready = 1'b0;
    src_in = 16'h4321;
    tick();
    src_in[3:0] = 4'd6;
    tick();
    src_in[3:0] = 4'd7;
    repeat (3) tick();
    n_tests++; if (fifo_level !== 4'd3 || drop_count !== 8'd1 || overflow !== 1'b1) begin n_fail++; $display("FAIL rm_setup: got level %0d cnt %0d ovf %b want 3 1 1", fifo_level, drop_count, overflow); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b want 0 right after rst", out_valid); end
    n_tests++; if (fifo_level !== 4'd0 || drop_count !== 8'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL rm_state: got level %0d cnt %0d ovf %b want 0 0 0", fifo_level, drop_count, overflow); end
    src_in = 16'h0090;
    exp_q.delete();
    tick(); tick();
    rst = 1'b0;
    exp_q.push_back(6'h19);
    out_ready = 1'b1;
    tick(); tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_early: out_valid got %b want 0", out_valid); end
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_data !== 6'h19) begin n_fail++; $display("FAIL rm_event: got valid %b data %h want 1 19", out_valid, out_data); end
    repeat (8) tick();
    n_tests++; if (exp_q.size() != 0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_single: got %0d outstanding valid %b want 0 0", exp_q.size(), out_valid); end
  endtask

  initial begin
    src_in     = '0;
    src_in2    = '0;
    out_ready  = 1'b0;
    out_ready2 = 1'b0;
    clr_drop   = 1'b0;
    clr_drop2  = 1'b0;
    test_reset();
    test_single_event();
    test_simultaneous();
    test_backpressure();
    test_fairness();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
